oled_spi_rx: RTL
================

# oled_spi_rx

Synchronous receiver/decoder for the 4-wire SPI stream that drives the on-board OLED (SCLK, MOSI, D/C, CS_n, RES_n). Oversamples the bus in the system clock domain, deserializes MSB-first bytes, and tags each byte as command (D/C=0) or pixel/data (D/C=1). Decoded bytes go into a small FIFO with a valid/ready output. The block sits beside the OLED driver as an in-chip monitor for bring-up and self-check, and serves as the bus-model front end of the chip-level testbench.

## Interface
Parameters:
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: flip-flop synchronizer depth on every SPI input; ≥2.

Ports:
- clock  in  1  system clock, 25 MHz.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- spi_sclk  in  1  SPI clock, asynchronous to clock, idle low (mode 0).
- spi_mosi  in  1  serial data, MSB first.
- spi_dc  in  1  data/command select; 0 = command, 1 = data.
- spi_cs_n  in  1  chip select, active-low.
- spi_res_n  in  1  panel reset, active-low.
- out_valid  out  1  FIFO head holds a byte.
- out_ready  in  1  consumer accepts head; pop when out_valid & out_ready.
- out_byte  out  8  head byte.
- out_dc  out  1  D/C tag of head byte.
- frame_err  out  1  sticky; CS_n rose with 1–7 bits collected.
- overflow  out  1  sticky; completed byte dropped because FIFO was full.
- panel_in_reset  out  1  synchronized, inverted spi_res_n.

## Operation
- Synchronizers: each SPI input passes through SYNC_STAGES flops. An edge register on the synced SCLK gives sclk_rise = synced high & previous low.
- States: IDLE (CS_n high or RES_n low), SHIFT. IDLE→SHIFT when synced CS_n=0 and RES_n=1. SHIFT→IDLE when CS_n=1 or RES_n=0.
- In SHIFT, each sclk_rise shifts synced MOSI into shift_reg[7:0] (LSB in, left shift) and increments bit_cnt (3 bits).
- On the sclk_rise where bit_cnt==7, push {synced DC, shift_reg[6:0], MOSI} into the FIFO. bit_cnt wraps to 0. D/C is sampled only on that 8th edge.
- CS_n deassert with bit_cnt≠0: discard partial byte, set frame_err, clear bit_cnt. With bit_cnt==0: clean end, no flag.
- RES_n low, any state: clear bit_cnt and shift_reg. FIFO contents are kept. Sticky flags are kept.
- FIFO full on push without simultaneous pop: byte dropped, overflow set. Full with push and pop in the same cycle: both happen, no overflow.
- Empty: out_valid=0. out_byte/out_dc hold the last value and are don't-care.
- Sticky flags clear only on reset.
- Reset values: out_valid=0, out_byte=0, out_dc=0, frame_err=0, overflow=0, panel_in_reset=0. FIFO empty, state IDLE, bit_cnt=0.

## Timing
- Required: spi_sclk high and low phases each ≥2 clock periods (SCLK ≤ clock/4 = 6.25 MHz). Faster SCLK is unsupported; no detection.
- Latency: out_valid rises SYNC_STAGES+2 cycles after the first clock edge that samples the 8th SCLK high (default 4).
- Back-to-back bytes: one byte per 8 SCLK periods, with no gap between bytes.
- FIFO: registered head, first-word-fall-through. A pop and a push of the same cycle are both visible next cycle. out_valid stays high across a pop if entries remain.
- frame_err and overflow assert the cycle after the causing event.
- Reset in mid-byte: state, counters and FIFO cleared at the next clock edge. SPI activity during reset is ignored. The first byte after reset starts at the first sclk_rise following CS_n low.

## Structure
- Shared package oled_pkg: typedef oled_byte_t (struct: logic dc, logic [7:0] data); localparam OLED_BITS_PER_BYTE = 8. The OLED driver uses the same package.
- Sub-module sync_fifo, parameterized width (9) and depth. It holds pointers one bit wider than the address for full/empty. It is reusable elsewhere in the chip.
- Synchronizer is a generate loop inside oled_spi_rx; no separate module.

## Test plan
- Single command 0xAF, DC=0, SCLK=clock/4, out_ready=1 → one pop: out_byte=0xAF, out_dc=0; out_valid high exactly 1 cycle; out_valid rises 4 cycles after the 8th SCLK rise.
- Burst 0x15,0x00,0x5F (DC=0) then 0xF8,0x1F (DC=1) in one CS frame, out_ready=1 → five bytes in order with tags 0,0,0,1,1; frame_err=0.
- out_ready=0, send 6 bytes 0x01..0x06, FIFO_DEPTH=4 → overflow=1 after 5th byte; with out_ready raised, pops read 0x01..0x04; 0x05 and 0x06 are never output.
- CS_n raised after 5 bits of 0xA5, then full byte 0x3C → frame_err=1; only 0x3C output.
- RES_n pulsed low mid-byte, then 0x81 sent → panel_in_reset=1 during pulse; output 0x81 only, no corrupted byte.
- reset asserted for 1 cycle with 2 bytes queued and 3 bits shifted → next cycle out_valid=0, frame_err=0, overflow=0; the next full byte decodes correctly.

Source files
------------

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_pkg
//  Description : Types and constants shared by the OLED SPI driver and the
//                OLED SPI receiver/monitor.
//                - oled_byte_t : one decoded bus byte plus its D/C tag
//                - rx_state_t  : receiver framing state
//  Revision    : 1.0  initial release
// ============================================================================
package oled_pkg;

  localparam int OLED_BITS_PER_BYTE = 8;

  typedef struct packed {
    logic       dc;     // 0 = command, 1 = pixel/data
    logic [7:0] data;
  } oled_byte_t;

  localparam int OLED_BYTE_W = $bits(oled_byte_t);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

endpackage : oled_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with a registered
//                head. Pointers carry one extra wrap bit so full and empty
//                are told apart without a separate counter.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_wr_en/i_wr_data  push request and data (ignored when full
//                                   unless a pop happens in the same cycle)
//                i_rd_en         pop request (ignored when empty)
//                o_rd_data       head entry (holds last value when empty)
//                o_valid         head entry is valid
//                o_full          all DEPTH entries occupied
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_valid,
  output logic             o_full
);

  localparam int c_ADDR_W = $clog2(DEPTH);

  logic [c_ADDR_W:0]  r_wr_ptr;
  logic [c_ADDR_W:0]  r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [WIDTH-1:0]   r_head;

  logic               w_empty;
  logic               w_full;
  logic               w_do_wr;
  logic               w_do_rd;
  logic [c_ADDR_W:0]  w_wr_ptr_nxt;
  logic [c_ADDR_W:0]  w_rd_ptr_nxt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                   (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]);

  // When full, a simultaneous pop frees the slot being written.
  assign w_do_rd = i_rd_en && !w_empty;
  assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

  assign w_wr_ptr_nxt = w_do_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
  assign w_rd_ptr_nxt = w_do_rd ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_wr_data;
    end
  end

  // The head register is loaded with whatever entry will sit at the read
  // pointer after this edge; if that entry is the one being written right
  // now it is taken straight from the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_rd_ptr_nxt != w_wr_ptr_nxt) begin
        if (w_do_wr && (w_rd_ptr_nxt == r_wr_ptr)) begin
          r_head <= i_wr_data;
        end else begin
          r_head <= r_mem[w_rd_ptr_nxt[c_ADDR_W-1:0]];
        end
      end
    end
  end

  assign o_rd_data = r_head;
  assign o_valid   = !w_empty;
  assign o_full    = w_full;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/oled_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : oled_spi_rx
//  Description : Oversampling receiver for the 4-wire OLED SPI bus (mode 0,
//                MSB first). Deserializes bytes, tags them command/data from
//                D/C on the 8th SCLK rise, and queues them in a FIFO.
//  Ports       : clock, reset        system clock, sync active-high reset
//                spi_sclk/mosi/dc/cs_n/res_n  raw asynchronous bus inputs
//                out_valid/out_ready/out_byte/out_dc  FIFO head handshake
//                frame_err           sticky: CS_n rose mid-byte
//                overflow            sticky: completed byte hit a full FIFO
//                panel_in_reset      synchronized, inverted spi_res_n
//  Revision    : 1.0  initial release
// ============================================================================
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs_n,
  input  logic       spi_res_n,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_dc,
  output logic       frame_err,
  output logic       overflow,
  output logic       panel_in_reset
);

  // --------------------------------------------------------------------------
  // Input synchronizers. Reset values match an idle bus (SCLK low, CS_n high,
  // RES_n high) so no false edge or frame is seen when reset releases.
  // --------------------------------------------------------------------------
  localparam int          c_NSIG     = 5;
  localparam int          c_IX_SCLK  = 0;
  localparam int          c_IX_MOSI  = 1;
  localparam int          c_IX_DC    = 2;
  localparam int          c_IX_CS_N  = 3;
  localparam int          c_IX_RES_N = 4;
  localparam logic [4:0]  c_SYNC_RST = 5'b11000;
  localparam logic [2:0]  c_CNT_LAST = 3'(OLED_BITS_PER_BYTE - 1);

  logic [c_NSIG-1:0] w_async;
  logic [c_NSIG-1:0] w_sync;

  assign w_async = {spi_res_n, spi_cs_n, spi_dc, spi_mosi, spi_sclk};

  genvar gi;
  generate
    for (gi = 0; gi < c_NSIG; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_pipe;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_pipe <= {SYNC_STAGES{c_SYNC_RST[gi]}};
        end else begin
          r_pipe <= {r_pipe[SYNC_STAGES-2:0], w_async[gi]};
        end
      end
      assign w_sync[gi] = r_pipe[SYNC_STAGES-1];
    end
  endgenerate

  logic w_sclk;
  logic w_mosi;
  logic w_dc;
  logic w_cs_n;
  logic w_res_n;

  assign w_sclk  = w_sync[c_IX_SCLK];
  assign w_mosi  = w_sync[c_IX_MOSI];
  assign w_dc    = w_sync[c_IX_DC];
  assign w_cs_n  = w_sync[c_IX_CS_N];
  assign w_res_n = w_sync[c_IX_RES_N];

  // --------------------------------------------------------------------------
  // Registered SCLK rise detect. MOSI and D/C are delayed alongside it so the
  // shifter sees the bit values that were present when the rise was sampled.
  // --------------------------------------------------------------------------
  logic r_sclk_prev;
  logic r_rise;
  logic r_mosi_d;
  logic r_dc_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sclk_prev <= 1'b0;
      r_rise      <= 1'b0;
      r_mosi_d    <= 1'b0;
      r_dc_d      <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;
      r_rise      <= w_sclk && !r_sclk_prev;
      r_mosi_d    <= w_mosi;
      r_dc_d      <= w_dc;
    end
  end

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  rx_state_t r_state;
  rx_state_t w_state_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_cs_n && w_res_n) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_n || !w_res_n) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shifter, byte assembly and sticky flags
  // --------------------------------------------------------------------------
  logic       w_shift_en;
  logic       w_frame_end;
  logic       w_pop;
  logic       w_fifo_full;
  logic       w_fifo_valid;
  oled_byte_t w_head;

  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_byte_vld;
  oled_byte_t r_byte;
  logic       r_frame_err;
  logic       r_overflow;

  assign w_shift_en  = (r_state == ST_SHIFT) && !w_cs_n && w_res_n && r_rise;
  assign w_frame_end = (r_state == ST_SHIFT) && w_cs_n && w_res_n;
  assign w_pop       = w_fifo_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;

      // Panel reset wins over everything and drops any partial byte; a
      // byte already completed (r_byte_vld) still reaches the FIFO.
      if (!w_res_n) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_frame_end) begin
        if (r_bit_cnt != 3'd0) begin
          r_frame_err <= 1'b1;
        end
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_shift_en) begin
        r_shift   <= {r_shift[6:0], r_mosi_d};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == c_CNT_LAST) begin
          r_byte_vld  <= 1'b1;
          r_byte.dc   <= r_dc_d;
          r_byte.data <= {r_shift[6:0], r_mosi_d};
        end
      end

      if (r_byte_vld && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (OLED_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .i_wr_en   (r_byte_vld),
    .i_wr_data (r_byte),
    .i_rd_en   (out_ready),
    .o_rd_data (w_head),
    .o_valid   (w_fifo_valid),
    .o_full    (w_fifo_full)
  );

  assign out_valid      = w_fifo_valid;
  assign out_byte       = w_head.data;
  assign out_dc         = w_head.dc;
  assign frame_err      = r_frame_err;
  assign overflow       = r_overflow;
  assign panel_in_reset = !w_res_n;

endmodule : oled_spi_rx
`default_nettype wire
